snake_dir_input: RTL

//  Input-side counterpart of the game display path. Takes the four raw direction

---
 rtl/snake_dir_input.sv | 132 +++++++++++++
 1 files changed

// File: rtl/snake_dir_input.sv
// Direction input path for the snake core: button sync, debounce and edge detect,
// legal-turn filtering and a small turn queue consumed one entry per game step.
module snake_dir_input #(
    parameter int         DEBOUNCE_CYCLES = 250000,
    parameter int         CNT_W           = 18,
    parameter int         QUEUE_DEPTH     = 2,
    parameter logic [1:0] RESET_DIR       = 2'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up,
    input  logic       right,
    input  logic       left,
    input  logic       down,
    input  logic       step,
    output logic [1:0] dir,
    output logic [2:0] q_count,
    output logic       turn_drop
);

    // Bit index equals direction code: 0=up 1=right 2=down 3=left
    logic [3:0]       raw;
    logic [3:0]       s1;
    logic [3:0]       s2;
    logic [3:0]       stable;
    logic [3:0]       prev;
    logic [3:0]       press;
    logic [CNT_W-1:0] cnt [4];

    assign raw   = {left, down, right, up};
    assign press = stable & ~prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= '0;
            s2     <= '0;
            stable <= '0;
            prev   <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1   <= raw;
            s2   <= s1;
            prev <= stable;
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    logic [1:0] mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [1:0] tail_ptr;
    logic [1:0] cand;
    logic [1:0] ref_dir;
    logic       has_press;
    logic       multi;
    logic       reject;
    logic       full;
    logic       pop;
    logic       push;
    logic       drop;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'(QUEUE_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        has_press = |press;
        multi     = (press & (press - 4'd1)) != 4'd0;
        if (press[0]) begin
            cand = 2'd0;
        end else if (press[1]) begin
            cand = 2'd1;
        end else if (press[2]) begin
            cand = 2'd2;
        end else begin
            cand = 2'd3;
        end
    end

    // Legality is judged against the last queued turn, so turns chain correctly
    always_comb begin
        tail_ptr = (wr_ptr == 2'd0) ? 2'(QUEUE_DEPTH - 1) : wr_ptr - 2'd1;
        ref_dir  = (q_count != 3'd0) ? mem[tail_ptr] : dir;
        reject   = (cand == ref_dir) || ((cand ^ ref_dir) == 2'd2);
        full     = q_count == 3'(QUEUE_DEPTH);
        pop      = step && (q_count != 3'd0);
        push     = has_press && !reject && (!full || pop);
        drop     = multi || (has_press && !push);
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= cand;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            q_count   <= 3'd0;
            dir       <= RESET_DIR;
            turn_drop <= 1'b0;
        end else begin
            turn_drop <= drop;
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                dir    <= mem[rd_ptr];
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !pop) begin
                q_count <= q_count + 3'd1;
            end else if (pop && !push) begin
                q_count <= q_count - 3'd1;
            end
        end
    end

endmodule
